// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-capable arbiter that shares the single
// write port of the async FIFO among NREQ producers in the write-clock domain.
// A producer is granted for at most MAXBURST words. Every re-arbitration
// passes through IDLE, so there is one dead cycle between consecutive grants.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int MAXBURST = 4,
    parameter int IDW      = 2
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    localparam int CNTW = $clog2(MAXBURST) + 1;

    // Count value of the final beat of a full-length burst.
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAXBURST - 1);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO  = CNTW'(0);
    // Pointer starts at the highest index so requester 0 wins first.
    localparam logic [IDW-1:0]  PTR_RST   = IDW'(NREQ - 1);
    localparam logic [IDW-1:0]  GNT_RST   = IDW'(0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [IDW-1:0]      grant_r;
    logic [IDW-1:0]      grant_s;
    logic [IDW-1:0]      last_r;
    logic [IDW-1:0]      last_s;
    logic [CNTW-1:0]     count_r;
    logic [CNTW-1:0]     count_s;
    logic                sel_valid_s;
    logic [DATASIZE-1:0] sel_word_s;
    logic                xfer_s;
    logic [DATASIZE-1:0] word_s [NREQ];

    // Round-robin search: first set bit strictly after 'last', wrapping.
    // Callers only use the result when at least one bit of 'valid' is set.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [NREQ-1:0] valid,
        input logic [IDW-1:0]  last
    );
        logic           found;
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        found = 1'b0;
        pick  = last;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    // Unpack the flat producer data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            word_s[i] = req_data[i*DATASIZE +: DATASIZE];
        end
    end

    // Mux the valid/data of the currently granted requester.
    always_comb begin
        sel_valid_s = req_valid[grant_r];
        sel_word_s  = word_s[grant_r];
    end

    // A word moves only in BURST, with the granted producer valid and room in the FIFO.
    always_comb begin
        if (state_r == BURST) begin
            xfer_s = sel_valid_s & ~wfull;
        end else begin
            xfer_s = 1'b0;
        end
    end

    // Next-state logic: grant in IDLE, count beats and decide release in BURST.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        count_s = count_r;
        case (state_r)
            IDLE: begin
                if (|req_valid) begin
                    grant_s = rr_pick(req_valid, last_r);
                    last_s  = grant_s;
                    count_s = CNT_ZERO;
                    state_s = BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (wfull) begin
                    // Backpressure: keep the grant and the beat count.
                    state_s = BURST;
                end else if (sel_valid_s) begin
                    if (count_r == LAST_BEAT) begin
                        count_s = CNT_ZERO;
                        state_s = IDLE;
                    end else begin
                        count_s = count_r + CNT_ONE;
                        state_s = BURST;
                    end
                end else begin
                    // Producer ran dry: release early so others can go.
                    count_s = CNT_ZERO;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                count_s = CNT_ZERO;
            end
        endcase
    end

    // State, grant, pointer and beat counter registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_r <= IDLE;
            grant_r <= GNT_RST;
            last_r  <= PTR_RST;
            count_r <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
            count_r <= count_s;
        end
    end

    // Write-port and handshake outputs, decoded from the registered grant.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        busy      = (state_r == BURST);
        winc      = xfer_s;
        grant_id  = grant_r;
        if ((state_r == BURST) && !wfull) begin
            req_ready[grant_r] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
        if (xfer_s) begin
            wdata = sel_word_s;
        end else begin
            wdata = {DATASIZE{1'b0}};
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed producer streams, a
// behavioural arbitration model compared on every cycle, and literal
// expectations for grant order, write order and per-cycle winc patterns.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
    localparam int IDW  = 2;
    localparam int DTW  = NREQ * DW;

    logic            wclk      = 1'b0;
    logic            wrst_n    = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [DTW-1:0]  req_data  = '0;
    logic [NREQ-1:0] req_ready;
    logic            wfull     = 1'b0;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [IDW-1:0]  grant_id;
    logic            busy;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DATASIZE(DW), .MAXBURST(MAXB), .IDW(IDW)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .grant_id(grant_id), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    int pend[$];     // pending producer words: (id << 8) | data
    int wlog[$];     // words seen on the FIFO write port
    int glog[$];     // grant_id at the start of each burst
    int rlog[$];     // words drained from the FIFO model
    int fifo_q[$];   // FIFO contents model

    // model of the arbiter: owner = -1 when no grant is active
    int m_owner, m_used, m_ptr, m_grant;

    int          cyc;
    int          fifo_cap = 0;
    int          prev_busy;
    bit          drain_en = 1'b0;
    bit          saw_full;
    logic [31:0] full_mask = '0;
    logic [31:0] hist = '0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_log(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            chk($sformatf("%s[%0d]", name, k), (k < got.size()) ? got[k] : -1, exp[k]);
        end
    endtask

    function automatic int front_idx(input int id);
        for (int k = 0; k < pend.size(); k++) begin
            if ((pend[k] >> 8) == id) return k;
        end
        return -1;
    endfunction

    function automatic logic vbit(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [DW-1:0] slice(input logic [DTW-1:0] d, input int i);
        logic [DTW-1:0] t;
        t = d >> (i * DW);
        return t[DW-1:0];
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_used    = 0;
        m_ptr     = NREQ - 1;
        m_grant   = 0;
        prev_busy = 0;
        cyc       = 0;
    endtask

    // present each producer's oldest pending word and the FIFO full flag
    task automatic drive();
        logic [NREQ-1:0] v;
        logic [DTW-1:0]  d;
        logic [31:0]     fm;
        int k;
        v = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = front_idx(i);
            if (k >= 0) begin
                v = v | (NREQ'(1) << i);
                d = d | (DTW'(pend[k] & 255) << (i * DW));
            end
        end
        req_valid = v;
        req_data  = d;
        fm        = full_mask >> cyc;
        wfull     = fm[0] || (fifo_cap > 0 && fifo_q.size() >= fifo_cap);
    endtask

    // one clock: compare on the falling edge, advance model, drive after rise
    task automatic tick();
        logic [NREQ-1:0] e_ready;
        logic            e_winc, e_busy;
        logic [DW-1:0]   e_wdata;
        logic [IDW-1:0]  e_grant;
        logic [31:0]     got_v, exp_v;
        int pick, k;
        @(negedge wclk);
        e_ready = '0;
        e_winc  = 1'b0;
        e_busy  = 1'b0;
        e_wdata = '0;
        e_grant = IDW'(m_grant);
        if (m_owner >= 0) begin
            e_busy  = 1'b1;
            e_ready = wfull ? '0 : (NREQ'(1) << m_owner);
            e_winc  = vbit(req_valid, m_owner) && !wfull;
            if (e_winc) e_wdata = slice(req_data, m_owner);
        end
        got_v = {16'h0000, busy, grant_id, req_ready, winc, wdata};
        exp_v = {16'h0000, e_busy, e_grant, e_ready, e_winc, e_wdata};
        chk($sformatf("outputs@cyc%0d", cyc), int'(got_v), int'(exp_v));

        hist = {hist[30:0], winc};
        if (wfull) saw_full = 1'b1;
        if (winc) begin
            wlog.push_back(int'(wdata));
            if (fifo_cap > 0) fifo_q.push_back(int'(wdata));
        end
        if (busy && prev_busy == 0) glog.push_back(int'(grant_id));
        prev_busy = int'(busy);
        for (int i = 0; i < NREQ; i++) begin
            if (vbit(req_valid, i) && vbit(req_ready, i)) begin
                k = front_idx(i);
                if (k >= 0) pend.delete(k);
            end
        end
        if (drain_en && fifo_q.size() > 0 && (cyc % 3 == 2)) rlog.push_back(fifo_q.pop_front());

        if (m_owner < 0) begin
            if (req_valid != '0) begin
                pick = -1;
                for (int j = 1; j <= NREQ; j++) begin
                    k = (m_ptr + j) % NREQ;
                    if (pick < 0 && vbit(req_valid, k)) pick = k;
                end
                m_owner = pick;
                m_ptr   = pick;
                m_grant = pick;
                m_used  = 0;
            end
        end else if (!wfull) begin
            if (vbit(req_valid, m_owner)) begin
                m_used++;
                if (m_used == MAXB) m_owner = -1;
            end else begin
                m_owner = -1;
            end
        end

        @(posedge wclk);
        #1;
        cyc++;
        drive();
    endtask

    // assert reset between clock edges, check outputs fell immediately
    task automatic do_reset();
        #2;
        wrst_n = 1'b0;
        #1;
        chk("rst_winc",  int'(winc),      0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_busy",  int'(busy),      0);
        chk("rst_grant", int'(grant_id),  0);
        chk("rst_wdata", int'(wdata),     0);
        model_reset();
        @(posedge wclk);
        @(posedge wclk);
        #3;
        wrst_n = 1'b1;
        drive();
    endtask

    task automatic run_until_idle(input int maxc, input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < maxc && !done; c++) begin
            tick();
            if (pend.size() == 0 && m_owner < 0 && fifo_q.size() == 0) done = 1'b1;
        end
        chk({name, "_completed"}, int'(done), 1);
    endtask

    task automatic clear_logs();
        wlog.delete();
        glog.delete();
        rlog.delete();
        hist = '0;
    endtask

    initial begin
        int exp_w[$];
        int exp_g[$];
        model_reset();
        #1;
        drive();
        do_reset();

        // fairness, interrupted by an asynchronous reset mid-burst
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) pend.push_back((i << 8) | (i * 16 + k));
        drive();
        tick(); tick(); tick();
        chk("pre_rst_winc", int'(winc), 1);
        do_reset();
        pend.delete();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) pend.push_back((i << 8) | (i * 16 + k));
        clear_logs();
        drive();
        run_until_idle(120, "fair");
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log("fair_grants", glog, exp_g);
        exp_w.delete();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NREQ; i++)
                for (int k = 0; k < 4; k++) exp_w.push_back(i * 16 + b * 4 + k);
        check_log("fair_words", wlog, exp_w);

        // single requester: two bursts, then release on valid low
        do_reset();
        clear_logs();
        for (int k = 0; k < 6; k++) pend.push_back((2 << 8) | (8'hA0 + k));
        drive();
        run_until_idle(60, "single");
        chk("single_winc_pattern", int'(hist[8:0]), int'(9'b011110110));
        check_log("single_grants", glog, '{2, 2});
        check_log("single_words", wlog, '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5});

        // backpressure on req1 after two words, five cycles long
        full_mask = 32'h0000_00F8;
        do_reset();
        clear_logs();
        for (int k = 0; k < 4; k++) pend.push_back((1 << 8) | (8'hB0 + k));
        drive();
        run_until_idle(60, "bp");
        full_mask = '0;
        chk("bp_winc_pattern", int'(hist[9:0]), int'(10'b0110000011));
        check_log("bp_grants", glog, '{1});
        check_log("bp_words", wlog, '{8'hB0, 8'hB1, 8'hB2, 8'hB3});

        // early release by req3, pointer wraps to req0
        do_reset();
        clear_logs();
        pend.push_back((2 << 8) | 8'hE0);
        drive();
        run_until_idle(20, "early_a");
        pend.push_back((3 << 8) | 8'hC0);
        pend.push_back((0 << 8) | 8'hD0);
        pend.push_back((0 << 8) | 8'hD1);
        hist = '0;
        drive();
        run_until_idle(40, "early_b");
        chk("early_winc_pattern", int'(hist[6:0]), int'(7'b0100110));
        check_log("early_grants", glog, '{2, 3, 0});
        check_log("early_words", wlog, '{8'hE0, 8'hC0, 8'hD0, 8'hD1});

        // end to end through a depth-8 FIFO model drained every third cycle
        fifo_cap = 8;
        drain_en = 1'b1;
        saw_full = 1'b0;
        do_reset();
        clear_logs();
        for (int k = 0; k < 8; k++) pend.push_back((0 << 8) | (8'h40 + k));
        for (int k = 0; k < 8; k++) pend.push_back((1 << 8) | (8'h50 + k));
        drive();
        run_until_idle(400, "e2e");
        exp_w.delete();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 4; k++) exp_w.push_back(8'h40 + i * 16 + b * 4 + k);
        check_log("e2e_writes", wlog, exp_w);
        check_log("e2e_reads", rlog, exp_w);
        chk("e2e_saw_full", int'(saw_full), 1);
        fifo_cap = 0;
        drain_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
